// File: rtl/adc_bridge_pkg.sv
// Shared sizing constants for the ADC serial bridge: result width, config word
// width, leading zero count and the combined shift register length.
package adc_bridge_pkg;

    localparam int RES_W  = 16;
    localparam int CFG_W  = 16;
    localparam int LEAD_W = 2;
    localparam int SR_W   = 2 * CFG_W;

endpackage

// File: rtl/adc_bridge_ctrl.sv
// Serial bridge between a host shift interface and an ADC: one shift register
// carries config bits in and result bits out on the same edges.
module adc_bridge_ctrl #(
    parameter int RES_W  = adc_bridge_pkg::RES_W,
    parameter int CFG_W  = adc_bridge_pkg::CFG_W,
    parameter int LEAD_W = adc_bridge_pkg::LEAD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dat_i,
    input  logic             load,
    input  logic [RES_W-1:0] adc_res,
    output logic [CFG_W-1:0] adc_cfg1,
    output logic [CFG_W-1:0] adc_cfg2,
    output logic             dat_o,
    output logic             tie1,
    output logic             tie0
);

    localparam int SR_W = 2 * CFG_W;

    logic [SR_W-1:0]  sr_q, sr_d;
    logic [CFG_W-1:0] cfg1_q, cfg1_d;
    logic [CFG_W-1:0] cfg2_q, cfg2_d;
    logic [SR_W-1:0]  load_pat;

    // Result sits above LEAD_W zeros so the host clocks out the lead bits first.
    always_comb begin
        load_pat = '0;
        load_pat[RES_W+LEAD_W-1:0] = {adc_res, {LEAD_W{1'b0}}};
    end

    always_comb begin
        sr_d   = {dat_i, sr_q[SR_W-1:1]};
        cfg1_d = cfg1_q;
        cfg2_d = cfg2_q;
        if (load) begin
            sr_d   = load_pat;
            cfg1_d = sr_q[CFG_W-1:0];
            cfg2_d = sr_q[SR_W-1:CFG_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q   <= '0;
            cfg1_q <= '0;
            cfg2_q <= '0;
        end else begin
            sr_q   <= sr_d;
            cfg1_q <= cfg1_d;
            cfg2_q <= cfg2_d;
        end
    end

    assign adc_cfg1 = cfg1_q;
    assign adc_cfg2 = cfg2_q;
    assign dat_o    = sr_q[0];
    assign tie1     = 1'b1;
    assign tie0     = 1'b0;

endmodule

// File: tb/tb_adc_bridge_ctrl.sv
// Bench for adc_bridge_ctrl: directed scenarios plus random traffic checked
// against a bit-queue model of the shift path.
module tb_adc_bridge_ctrl;
    import adc_bridge_pkg::*;

    logic             clk;
    logic             rst;
    logic             dat_i;
    logic             load;
    logic [RES_W-1:0] adc_res;
    logic [CFG_W-1:0] adc_cfg1;
    logic [CFG_W-1:0] adc_cfg2;
    logic             dat_o;
    logic             tie1;
    logic             tie0;

    int n_cmp = 0;
    int n_err = 0;

    // Model: m_sr[0] is the bit currently presented on dat_o.
    bit               m_sr[$];
    logic [CFG_W-1:0] m_cfg1;
    logic [CFG_W-1:0] m_cfg2;

    adc_bridge_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .dat_i    (dat_i),
        .load     (load),
        .adc_res  (adc_res),
        .adc_cfg1 (adc_cfg1),
        .adc_cfg2 (adc_cfg2),
        .dat_o    (dat_o),
        .tie1     (tie1),
        .tie0     (tie0)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [CFG_W-1:0] m_word(input int base);
        logic [CFG_W-1:0] w;
        for (int k = 0; k < CFG_W; k++) w[k] = m_sr[base + k];
        return w;
    endfunction

    task automatic model_reset();
        m_sr.delete();
        for (int k = 0; k < SR_W; k++) m_sr.push_back(1'b0);
        m_cfg1 = '0;
        m_cfg2 = '0;
    endtask

    task automatic model_edge(input logic l, input logic d, input logic [RES_W-1:0] r);
        if (l) begin
            m_cfg1 = m_word(0);
            m_cfg2 = m_word(CFG_W);
            m_sr.delete();
            for (int k = 0; k < LEAD_W; k++) m_sr.push_back(1'b0);
            for (int k = 0; k < RES_W; k++) m_sr.push_back(r[k]);
            while (m_sr.size() < SR_W) m_sr.push_back(1'b0);
        end else begin
            void'(m_sr.pop_front());
            m_sr.push_back(d);
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".dat_o"}, 32'(dat_o), 32'(m_sr[0]));
        check_eq({tag, ".cfg1"}, 32'(adc_cfg1), 32'(m_cfg1));
        check_eq({tag, ".cfg2"}, 32'(adc_cfg2), 32'(m_cfg2));
    endtask

    // driver: apply one edge's worth of inputs, update the model, check #1 later
    task automatic cycle(input string tag, input logic l, input logic d, input logic [RES_W-1:0] r);
        load    = l;
        dat_i   = d;
        adc_res = r;
        @(posedge clk);
        model_edge(l, d, r);
        #1;
        check_all(tag);
    endtask

    // asynchronous reset pulse placed between clock edges
    task automatic reset_pulse(input string tag);
        rst = 1'b1;
        #2;
        model_reset();
        check_all(tag);
        #2;
        rst = 1'b0;
    endtask

    initial begin : main
        logic [31:0]      word;
        logic [19:0]      samples;
        logic [RES_W-1:0] r;

        // reset with random inputs
        rst     = 1'b1;
        dat_i   = 1'($urandom_range(0, 1));
        load    = 1'($urandom_range(0, 1));
        adc_res = RES_W'($urandom);
        #3;
        model_reset();
        check_all("reset");
        check_eq("reset.tie1", 32'(tie1), 32'd1);
        check_eq("reset.tie0", 32'(tie0), 32'd0);
        #19;
        check_all("reset_held");
        rst = 1'b0;

        // config entry
        word = 32'h12345678;
        for (int i = 0; i < SR_W; i++) cycle("cfg_shift", 1'b0, word[i], RES_W'($urandom));
        cycle("cfg_load", 1'b1, 1'b0, RES_W'($urandom));
        check_eq("cfg.word1", 32'(adc_cfg1), 32'h5678);
        check_eq("cfg.word2", 32'(adc_cfg2), 32'h1234);

        // readout
        cycle("rd_load", 1'b1, 1'b0, 16'habcd);
        for (int i = 0; i < 20; i++) begin
            samples[i] = dat_o;
            cycle("rd_shift", 1'b0, 1'b0, 16'habcd);
        end
        check_eq("readout.samples", 32'(samples), 32'h2af34);

        // load precedence over dat_i, then expose sr via a second load
        r = RES_W'($urandom);
        cycle("prec_load", 1'b1, 1'b1, r);
        check_eq("prec.dat_o", 32'(dat_o), 32'd0);
        cycle("prec_probe", 1'b1, 1'b1, RES_W'($urandom));
        check_eq("prec.cfg1", 32'(adc_cfg1), 32'({r[13:0], 2'b00}));
        check_eq("prec.cfg2", 32'(adc_cfg2), 32'({14'd0, r[15:14]}));

        // reset mid-shift
        for (int i = 0; i < 10; i++) cycle("mid_shift", 1'b0, 1'($urandom_range(0, 1)), RES_W'($urandom));
        reset_pulse("mid_reset");
        word = $urandom;
        for (int i = 0; i < SR_W; i++) cycle("mid_new", 1'b0, word[i], RES_W'($urandom));
        cycle("mid_load", 1'b1, 1'b0, RES_W'($urandom));
        check_eq("mid.cfg1", 32'(adc_cfg1), 32'(word[15:0]));
        check_eq("mid.cfg2", 32'(adc_cfg2), 32'(word[31:16]));

        // double load
        cycle("dbl_load1", 1'b1, 1'b0, 16'h0001);
        cycle("dbl_load2", 1'b1, 1'b0, 16'h0001);
        check_eq("dbl.cfg1", 32'(adc_cfg1), 32'h0004);
        check_eq("dbl.cfg2", 32'(adc_cfg2), 32'h0000);

        // partial shift then load keeps residual bits
        for (int i = 0; i < 5; i++) cycle("part_shift", 1'b0, 1'b1, 16'h0);
        cycle("part_load", 1'b1, 1'b0, 16'h0);

        // random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) reset_pulse("rnd_reset");
            cycle("rnd", 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), RES_W'($urandom));
        end
        check_eq("end.tie1", 32'(tie1), 32'd1);
        check_eq("end.tie0", 32'(tie0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
